// File: rtl/sr_mdu_pkg.sv
// rtl/sr_mdu_pkg.sv - MDU op encodings and op-class helpers shared by control and sr_mdu
package sr_mdu_pkg;

    localparam logic [2:0] MDU_MUL    = 3'b000;
    localparam logic [2:0] MDU_MULH   = 3'b001;
    localparam logic [2:0] MDU_MULHSU = 3'b010;
    localparam logic [2:0] MDU_MULHU  = 3'b011;
    localparam logic [2:0] MDU_DIV    = 3'b100;
    localparam logic [2:0] MDU_DIVU   = 3'b101;
    localparam logic [2:0] MDU_REM    = 3'b110;
    localparam logic [2:0] MDU_REMU   = 3'b111;

    function automatic logic op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic op_is_rem(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

    function automatic logic op_a_signed(input logic [2:0] op);
        return (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
    endfunction

    function automatic logic op_b_signed(input logic [2:0] op);
        return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
    endfunction

endpackage

// File: rtl/sr_mdu_divstep.sv
// rtl/sr_mdu_divstep.sv - one combinational restoring-divide step on magnitudes
module sr_mdu_divstep #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic            dividend_bit_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic            quo_bit_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    // rem_i < divisor keeps |trial| below 2^XLEN, so the top bit is a clean borrow flag
    always_comb begin
        shifted   = {rem_i, dividend_bit_i};
        trial     = shifted - {1'b0, divisor_i};
        quo_bit_o = ~trial[XLEN];
        rem_o     = quo_bit_o ? trial[XLEN-1:0] : shifted[XLEN-1:0];
    end

endmodule

// File: rtl/sr_mdu.sv
// rtl/sr_mdu.sv - iterative RV32M multiply/divide unit; SR_MDU_EARLY_OUT_EN enables zero/special-case early exit
module sr_mdu
    import sr_mdu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            mdu_clear,
    input  logic            mdu_vld_in,
    input  logic [2:0]      mdu_op,
    input  logic [XLEN-1:0] mdu_srcA,
    input  logic [XLEN-1:0] mdu_srcB,
    output logic            mdu_vld_out,
    output logic [XLEN-1:0] mdu_result,
    output logic            mdu_busy
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0] N_MUL = CW'(XLEN / MUL_STEP);
    localparam logic [CW-1:0] N_DIV = CW'(XLEN);
    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q;
    logic              sa_q, sb_q;
    logic [XLEN-1:0]   a_q, b_q;
    logic [2*XLEN-1:0] acc_q;
    logic [CW-1:0]     cnt_q;
    logic [XLEN-1:0]   result_q;

    logic              in_sa, in_sb;
    logic [XLEN-1:0]   in_a_mag, in_b_mag;
    logic              early_exit;
    logic [XLEN-1:0]   early_result;

    always_comb begin
        in_sa    = op_a_signed(mdu_op) & mdu_srcA[XLEN-1];
        in_sb    = op_b_signed(mdu_op) & mdu_srcB[XLEN-1];
        in_a_mag = in_sa ? -mdu_srcA : mdu_srcA;
        in_b_mag = in_sb ? -mdu_srcB : mdu_srcB;
    end

`ifdef SR_MDU_EARLY_OUT_EN
    logic in_ovf;
    always_comb begin
        in_ovf       = op_is_div(mdu_op) && op_a_signed(mdu_op) &&
                       (mdu_srcA == XMIN) && (mdu_srcB == '1);
        early_exit   = 1'b0;
        early_result = '0;
        if (op_is_div(mdu_op)) begin
            if (mdu_srcB == '0) begin
                early_exit   = 1'b1;
                early_result = op_is_rem(mdu_op) ? mdu_srcA : '1;
            end else if (in_ovf) begin
                early_exit   = 1'b1;
                early_result = op_is_rem(mdu_op) ? '0 : XMIN;
            end
        end else if ((mdu_srcA == '0) || (mdu_srcB == '0)) begin
            early_exit = 1'b1;
        end
    end
`else
    assign early_exit   = 1'b0;
    assign early_result = '0;
`endif

    // Multiply: acc holds {partial product, remaining multiplier bits}, shifted right MUL_STEP per cycle
    logic [XLEN+MUL_STEP-1:0] mul_part, mul_sum;
    logic [2*XLEN-1:0]        mul_next;

    always_comb begin
        mul_part = '0;
        for (int k = 0; k < MUL_STEP; k++) begin
            if (acc_q[k]) begin
                mul_part = mul_part + ({{MUL_STEP{1'b0}}, a_q} << k);
            end
        end
        mul_sum  = {{MUL_STEP{1'b0}}, acc_q[2*XLEN-1:XLEN]} + mul_part;
        mul_next = {mul_sum, acc_q[XLEN-1:MUL_STEP]};
    end

    // Divide: acc holds {partial remainder, dividend bits shifting out / quotient bits shifting in}
    logic [XLEN-1:0]   div_rem;
    logic              div_qbit;
    logic [2*XLEN-1:0] div_next;

    sr_mdu_divstep #(.XLEN(XLEN)) u_divstep (
        .rem_i          (acc_q[2*XLEN-1:XLEN]),
        .dividend_bit_i (acc_q[XLEN-1]),
        .divisor_i      (b_q),
        .rem_o          (div_rem),
        .quo_bit_o      (div_qbit)
    );

    assign div_next = {div_rem, acc_q[XLEN-2:0], div_qbit};

    logic [2*XLEN-1:0] calc_next;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo_s, rem_s, final_res;

    always_comb begin
        calc_next = op_is_div(op_q) ? div_next : mul_next;
        prod      = (sa_q ^ sb_q) ? -calc_next : calc_next;
        quo_s     = (sa_q ^ sb_q) ? -calc_next[XLEN-1:0] : calc_next[XLEN-1:0];
        rem_s     = sa_q ? -calc_next[2*XLEN-1:XLEN] : calc_next[2*XLEN-1:XLEN];
        if (b_q == '0) begin
            quo_s = '1;
            rem_s = sa_q ? -a_q : a_q;
        end
        if (op_is_div(op_q)) begin
            final_res = op_is_rem(op_q) ? rem_s : quo_s;
        end else begin
            final_res = (op_q == MDU_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (mdu_clear) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (mdu_vld_in) state_d = early_exit ? S_DONE : S_CALC;
                S_CALC:  if (cnt_q == CW'(1)) state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        mdu_vld_out = (state_q == S_DONE);
        mdu_busy    = (state_q != S_IDLE);
        mdu_result  = result_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            op_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else if (!mdu_clear) begin
            case (state_q)
                S_IDLE: begin
                    if (mdu_vld_in) begin
                        op_q  <= mdu_op;
                        sa_q  <= in_sa;
                        sb_q  <= in_sb;
                        a_q   <= in_a_mag;
                        b_q   <= in_b_mag;
                        acc_q <= {{XLEN{1'b0}}, (op_is_div(mdu_op) ? in_a_mag : in_b_mag)};
                        cnt_q <= op_is_div(mdu_op) ? N_DIV : N_MUL;
                        if (early_exit) begin
                            result_q <= early_result;
                        end
                    end
                end
                S_CALC: begin
                    acc_q <= calc_next;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        result_q <= final_res;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sr_mdu.sv
// tb/tb_sr_mdu.sv - self-checking bench for sr_mdu: vector table, corner sequences, random ops vs 64-bit model
module tb_sr_mdu;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mdu_clear;
    logic        mdu_vld_in;
    logic [2:0]  mdu_op;
    logic [31:0] mdu_srcA, mdu_srcB;
    logic        mdu_vld_out;
    logic [31:0] mdu_result;
    logic        mdu_busy;

    int passed = 0;
    int total  = 0;
    logic [31:0] last_res;

    sr_mdu #(.XLEN(32), .MUL_STEP(1)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .mdu_clear   (mdu_clear),
        .mdu_vld_in  (mdu_vld_in),
        .mdu_op      (mdu_op),
        .mdu_srcA    (mdu_srcA),
        .mdu_srcB    (mdu_srcB),
        .mdu_vld_out (mdu_vld_out),
        .mdu_result  (mdu_result),
        .mdu_busy    (mdu_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        case (op)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % longint'({32'b0, b}); return p[31:0];
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef SR_MDU_EARLY_OUT_EN
        if (!op[2] && (a == 0 || b == 0)) return 1;
        if (op[2] && b == 0) return 1;
        if (op[2] && !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`endif
        return 33;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Called at #1 after a posedge with the DUT idle; start is sampled at the next edge (cycle T)
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int inject_at);
        int lat;
        int busy_low;
        lat = 0;
        busy_low = 0;
        mdu_vld_in = 1'b1;
        mdu_op = op;
        mdu_srcA = a;
        mdu_srcB = b;
        @(posedge clk); #1;
        mdu_vld_in = 1'b0;
        mdu_srcA = $urandom;
        mdu_srcB = $urandom;
        for (int k = 1; k <= 40; k++) begin
            if (mdu_busy !== 1'b1) busy_low++;
            if (mdu_vld_out === 1'b1) begin
                lat = k;
                break;
            end
            if (k == inject_at) begin
                mdu_vld_in = 1'b1;
                mdu_op = 3'b101;
                mdu_srcA = 32'd100;
                mdu_srcB = 32'd7;
            end else begin
                mdu_vld_in = 1'b0;
            end
            @(posedge clk); #1;
        end
        mdu_vld_in = 1'b0;
        check({name, " latency"}, 32'(lat), 32'(exp_lat(op, a, b)));
        check({name, " result"}, mdu_result, exp_res);
        check({name, " busy"}, 32'(busy_low), 32'd0);
        last_res = exp_res;
        @(posedge clk); #1;
        check({name, " back idle"}, {30'b0, mdu_vld_out, mdu_busy}, 32'd0);
    endtask

    initial begin
        int vcount;
        int bcount;
        reset_n = 1'b0;
        mdu_clear = 1'b0;
        mdu_vld_in = 1'b0;
        mdu_op = 3'b000;
        mdu_srcA = '0;
        mdu_srcB = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("reset vld_out", {31'b0, mdu_vld_out}, 32'd0);
        check("reset busy", {31'b0, mdu_busy}, 32'd0);
        check("reset result", mdu_result, 32'd0);
        last_res = 32'd0;

        // start and clear together in IDLE: the start is dropped
        mdu_vld_in = 1'b1;
        mdu_clear = 1'b1;
        mdu_op = 3'b000;
        mdu_srcA = 32'd3;
        mdu_srcB = 32'd4;
        @(posedge clk); #1;
        mdu_vld_in = 1'b0;
        mdu_clear = 1'b0;
        vcount = 0;
        bcount = 0;
        for (int k = 0; k < 36; k++) begin
            if (mdu_vld_out === 1'b1) vcount++;
            if (mdu_busy === 1'b1) bcount++;
            @(posedge clk); #1;
        end
        check("vld+clear no vld_out", 32'(vcount), 32'd0);
        check("vld+clear no busy", 32'(bcount), 32'd0);

        vecs[0]  = '{3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vecs[2]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[3]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
        vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
        vecs[6]  = '{3'b101, 32'd100,       32'd7,         32'd14};
        vecs[7]  = '{3'b111, 32'd100,       32'd7,         32'd2};
        vecs[8]  = '{3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF};
        vecs[9]  = '{3'b111, 32'd5,         32'd0,         32'd5};
        vecs[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
        vecs[12] = '{3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF};
        vecs[13] = '{3'b110, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB};
        vecs[14] = '{3'b000, 32'd0,         32'd12345,     32'd0};
        vecs[15] = '{3'b001, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF};
        for (int i = 0; i < 16; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, 0);
        end

        // start during CALC is ignored; original MUL result is delivered on time
        run_op("vld_in in calc", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 5);

        // reset mid-operation: outputs and result drop to zero, op never completes
        mdu_vld_in = 1'b1;
        mdu_op = 3'b000;
        mdu_srcA = 32'd7;
        mdu_srcB = 32'hFFFF_FFFD;
        @(posedge clk); #1;
        mdu_vld_in = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        check("reset mid vld_out", {31'b0, mdu_vld_out}, 32'd0);
        check("reset mid busy", {31'b0, mdu_busy}, 32'd0);
        check("reset mid result", mdu_result, 32'd0);
        vcount = 0;
        for (int k = 0; k < 40; k++) begin
            if (mdu_vld_out === 1'b1) vcount++;
            @(posedge clk); #1;
        end
        check("reset mid no vld_out", 32'(vcount), 32'd0);
        last_res = 32'd0;

        run_op("pre-clear mul", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);

        // clear during DIV at T+10, new MUL started at T+12
        mdu_vld_in = 1'b1;
        mdu_op = 3'b100;
        mdu_srcA = 32'd100;
        mdu_srcB = 32'd7;
        @(posedge clk); #1;
        mdu_vld_in = 1'b0;
        vcount = 0;
        for (int k = 0; k < 9; k++) begin
            if (mdu_vld_out === 1'b1) vcount++;
            @(posedge clk); #1;
        end
        mdu_clear = 1'b1;
        @(posedge clk); #1;
        mdu_clear = 1'b0;
        check("clear no vld_out", 32'(vcount) + {31'b0, mdu_vld_out}, 32'd0);
        check("clear busy", {31'b0, mdu_busy}, 32'd0);
        check("clear result held", mdu_result, last_res);
        @(posedge clk); #1;
        run_op("mul after clear", 3'b000, 32'd3, 32'd4, 32'd12, 0);

        for (int i = 0; i < 30; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(0, 7));
            a = pick_operand();
            b = pick_operand();
            run_op($sformatf("rnd%0d op%0d %h %h", i, op, a, b), op, a, b, ref_mdu(op, a, b), 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", passed, total);
        $fatal(1);
    end

endmodule
